// File: rtl/clint_responder_pkg.sv
// Shared definitions for the CLINT responder: register offsets, FSM and
// decode encodings, and the byte-merge helper used for partial writes.
package clint_responder_pkg;

    localparam logic [31:0] MSIP_OFF     = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_OFF = 32'h0000_4000;
    localparam logic [31:0] MTIME_OFF    = 32'h0000_BFF8;

    // All ones keeps the timer interrupt quiet until software programs it.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE     = 2'd0,
        SEL_MSIP     = 2'd1,
        SEL_MTIMECMP = 2'd2,
        SEL_MTIME    = 2'd3
    } sel_e;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                                input logic [63:0] new_v,
                                                input logic [7:0]  be);
        logic [63:0] res;
        res = old_v;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for mtime: emits a one-cycle tick every TICK_DIV clocks
// (every clock when TICK_DIV is 1).
module clint_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint_responder.sv
// CLINT bus responder: holds msip/mtime/mtimecmp behind a three-state
// IDLE/ACCESS/DONE handshake and drives them straight to the core.
module clint_responder
    import clint_responder_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int TICK_DIV  = 1,
    parameter int ADDR_W    = 16
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_SIZE/8-1:0] byte_en,
    input  logic [DATA_SIZE-1:0]   wr_data,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   busy,
    output logic [DATA_SIZE-1:0]   msip,
    output logic [63:0]            mtime,
    output logic [63:0]            mtimecmp
);

    localparam int BE_W = DATA_SIZE / 8;
    localparam logic [31:0] LOW_MASK = 32'(BE_W - 1);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_SIZE-1:0]  wdata_q, wdata_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic                  wr_op_q, wr_op_d;
    logic [DATA_SIZE-1:0]  rd_data_q, rd_data_d;
    logic                  msip_q, msip_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;

    logic                  tick;
    sel_e                  sel;
    logic                  hi_half;
    logic [31:0]           word_addr;
    logic [63:0]           wr_data64;
    logic [7:0]            be64;
    logic [63:0]           rd_val;
    logic [DATA_SIZE-1:0]  rd_word;

    clint_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (CLK_I),
        .rst_i  (RST_I),
        .tick_o (tick)
    );

    // Decode the latched offset; sub-word address bits are masked off.
    always_comb begin
        word_addr = 32'(addr_q) & ~LOW_MASK;
        sel       = SEL_NONE;
        hi_half   = 1'b0;
        if (word_addr == MSIP_OFF) begin
            sel = SEL_MSIP;
        end else if (word_addr == MTIMECMP_OFF) begin
            sel = SEL_MTIMECMP;
        end else if (DATA_SIZE == 32 && word_addr == MTIMECMP_OFF + 32'd4) begin
            sel     = SEL_MTIMECMP;
            hi_half = 1'b1;
        end else if (word_addr == MTIME_OFF) begin
            sel = SEL_MTIME;
        end else if (DATA_SIZE == 32 && word_addr == MTIME_OFF + 32'd4) begin
            sel     = SEL_MTIME;
            hi_half = 1'b1;
        end
    end

    always_comb begin
        case (sel)
            SEL_MSIP:     rd_val = {63'd0, msip_q};
            SEL_MTIMECMP: rd_val = mtimecmp_q;
            SEL_MTIME:    rd_val = mtime_q;
            default:      rd_val = 64'd0;
        endcase
    end

    // Steer a bus word onto the matching half of a 64-bit register.
    if (DATA_SIZE == 32) begin : g_half
        assign wr_data64 = hi_half ? {wdata_q, 32'h0} : {32'h0, wdata_q};
        assign be64      = hi_half ? {be_q, 4'h0} : {4'h0, be_q};
        assign rd_word   = hi_half ? rd_val[63:32] : rd_val[31:0];
    end else begin : g_full
        assign wr_data64 = wdata_q;
        assign be64      = be_q;
        assign rd_word   = rd_val;
    end

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_op_d    = wr_op_q;
        rd_data_d  = rd_data_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_en || wr_en) begin
                    addr_d  = addr;
                    wdata_d = wr_data;
                    be_d    = byte_en;
                    wr_op_d = wr_en;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                if (wr_op_q) begin
                    case (sel)
                        SEL_MSIP: begin
                            if (be64[0]) msip_d = wr_data64[0];
                        end
                        SEL_MTIMECMP: begin
                            mtimecmp_d = merge_bytes(mtimecmp_q, wr_data64, be64);
                        end
                        SEL_MTIME: begin
                            // Bus write beats the tick: merge onto the pre-increment value.
                            if (|be64) mtime_d = merge_bytes(mtime_q, wr_data64, be64);
                        end
                        default: ;
                    endcase
                end else begin
                    rd_data_d = rd_word;
                end
            end
            ST_DONE: begin
                if (!rd_en && !wr_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wr_op_q    <= 1'b0;
            rd_data_q  <= '0;
            msip_q     <= 1'b0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RST;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wr_op_q    <= wr_op_d;
            rd_data_q  <= rd_data_d;
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign busy     = !RST_I && ((state_q == ST_IDLE && (rd_en || wr_en)) ||
                                 state_q == ST_ACCESS);
    assign rd_data  = rd_data_q;
    assign msip     = {{(DATA_SIZE-1){1'b0}}, msip_q};
    assign mtime    = mtime_q;
    assign mtimecmp = mtimecmp_q;

endmodule

// File: tb/tb_clint_responder.sv
// Self-checking bench for clint_responder (32-bit bus): a TICK_DIV=1 instance
// under bus traffic and an idle TICK_DIV=4 instance for prescaler timing.
module tb_clint_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] addr = '0;
    logic [3:0]  byte_en = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        busy;
    logic [31:0] msip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    logic        idle_rd = 1'b0;
    logic        idle_wr = 1'b0;
    logic [15:0] idle_addr = '0;
    logic [3:0]  idle_be = '0;
    logic [31:0] idle_wd = '0;
    logic [31:0] rd_data4;
    logic        busy4;
    logic [31:0] msip4;
    logic [63:0] mtime4;
    logic [63:0] mtimecmp4;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    clint_responder #(.DATA_SIZE(32), .TICK_DIV(1), .ADDR_W(16)) dut (
        .CLK_I(clk), .RST_I(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .byte_en(byte_en), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
        .msip(msip), .mtime(mtime), .mtimecmp(mtimecmp)
    );

    clint_responder #(.DATA_SIZE(32), .TICK_DIV(4), .ADDR_W(16)) dut_div4 (
        .CLK_I(clk), .RST_I(rst), .rd_en(idle_rd), .wr_en(idle_wr), .addr(idle_addr),
        .byte_en(idle_be), .wr_data(idle_wd), .rd_data(rd_data4), .busy(busy4),
        .msip(msip4), .mtime(mtime4), .mtimecmp(mtimecmp4)
    );

    // One full handshake; returns at the first negedge with busy low.
    task automatic bus_xfer(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [3:0] be, input logic [31:0] d,
                            output int busy_cycles);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; addr = a; byte_en = be; wr_data = d;
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
        end
        checks++;
        if (busy_cycles >= 10) begin
            failures++;
            $display("FAIL handshake_timeout addr=%h busy_cycles=%0d limit=10", a, busy_cycles);
        end
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (msip !== 32'h0) begin failures++; $display("FAIL reset_msip got=%h exp=%h", msip, 32'h0); end
        checks++; if (mtime !== 64'h0) begin failures++; $display("FAIL reset_mtime got=%h exp=%h", mtime, 64'h0); end
        checks++; if (mtimecmp !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL reset_mtimecmp got=%h exp=%h", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 32'h0); end
        repeat (7) @(negedge clk);
        checks++; if (mtime4 !== 64'd1) begin failures++; $display("FAIL div4_after7 got=%0d exp=1", mtime4); end
        @(negedge clk);
        checks++; if (mtime4 !== 64'd2) begin failures++; $display("FAIL div4_after8 got=%0d exp=2", mtime4); end
    endtask

    task automatic test_msip();
        int bc;
        logic [31:0] e;
        bus_xfer(1'b0, 1'b1, 16'h0000, 4'hF, 32'hFFFF_FFFF, bc);
        checks++; if (bc !== 2) begin failures++; $display("FAIL msip_busy_cycles got=%0d exp=2", bc); end
        checks++; if (msip !== 32'h1) begin failures++; $display("FAIL msip_write got=%h exp=%h", msip, 32'h1); end
        exp_q.push_back(32'h0000_0001);
        bus_xfer(1'b1, 1'b0, 16'h0000, 4'hF, 32'h0, bc);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin failures++; $display("FAIL msip_read got=%h exp=%h", rd_data, e); end
    endtask

    task automatic test_mtimecmp_halves();
        int bc;
        logic [31:0] e;
        bus_xfer(1'b0, 1'b1, 16'h4000, 4'hF, 32'h0000_0100, bc);
        checks++; if (mtimecmp !== 64'hFFFF_FFFF_0000_0100) begin failures++; $display("FAIL cmp_low_only got=%h exp=%h", mtimecmp, 64'hFFFF_FFFF_0000_0100); end
        bus_xfer(1'b0, 1'b1, 16'h4004, 4'hF, 32'h0000_0000, bc);
        checks++; if (mtimecmp !== 64'h100) begin failures++; $display("FAIL cmp_both_halves got=%h exp=%h", mtimecmp, 64'h100); end
        exp_q.push_back(32'h0);
        bus_xfer(1'b1, 1'b0, 16'h4004, 4'hF, 32'h0, bc);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin failures++; $display("FAIL cmp_read_hi got=%h exp=%h", rd_data, e); end
        exp_q.push_back(32'h100);
        bus_xfer(1'b1, 1'b0, 16'h4003, 4'hF, 32'h0, bc);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin failures++; $display("FAIL cmp_read_unaligned got=%h exp=%h", rd_data, e); end
    endtask

    task automatic test_byte_merge();
        int bc;
        bus_xfer(1'b0, 1'b1, 16'h4000, 4'b0010, 32'h0000_AB00, bc);
        checks++; if (mtimecmp !== 64'h0000_AB00) begin failures++; $display("FAIL byte_merge got=%h exp=%h", mtimecmp, 64'h0000_AB00); end
        bus_xfer(1'b0, 1'b1, 16'h4000, 4'b0000, 32'hFFFF_FFFF, bc);
        checks++; if (bc !== 2) begin failures++; $display("FAIL be0_busy_cycles got=%0d exp=2", bc); end
        checks++; if (mtimecmp !== 64'h0000_AB00) begin failures++; $display("FAIL be0_no_change got=%h exp=%h", mtimecmp, 64'h0000_AB00); end
    endtask

    task automatic test_mtime_collision();
        int bc;
        bus_xfer(1'b0, 1'b1, 16'hBFFC, 4'hF, 32'h0, bc);
        bus_xfer(1'b0, 1'b1, 16'hBFF8, 4'hF, 32'h10, bc);
        checks++; if (mtime !== 64'h10) begin failures++; $display("FAIL collision_write got=%h exp=%h", mtime, 64'h10); end
        @(negedge clk);
        checks++; if (mtime !== 64'h11) begin failures++; $display("FAIL collision_next got=%h exp=%h", mtime, 64'h11); end
        bus_xfer(1'b0, 1'b1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF, bc);
        bus_xfer(1'b0, 1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF, bc);
        checks++; if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=%h", mtime, 64'hFFFF_FFFF_FFFF_FFFF); end
        @(negedge clk);
        checks++; if (mtime !== 64'h0) begin failures++; $display("FAIL wrap_to_zero got=%h exp=%h", mtime, 64'h0); end
    endtask

    // rd_en held 5 cycles: mtime is loaded to 0x100, so the single capture sees 0x102.
    task automatic test_read_hold();
        int bc;
        logic [31:0] e;
        logic exp_busy;
        bus_xfer(1'b0, 1'b1, 16'hBFF8, 4'hF, 32'h100, bc);
        @(posedge clk); #1;
        rd_en = 1'b1; addr = 16'hBFF8; byte_en = 4'hF;
        exp_q.push_back(32'h102);
        exp_q.push_back(32'h102);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_busy = (c < 2);
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL hold_busy_c%0d got=%b exp=%b", c, busy, exp_busy); end
            if (c == 2 || c == 4) begin
                e = exp_q.pop_front();
                checks++; if (rd_data !== e) begin failures++; $display("FAIL hold_rd_c%0d got=%h exp=%h", c, rd_data, e); end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_unmapped();
        int bc;
        logic [31:0] e;
        exp_q.push_back(32'h0);
        bus_xfer(1'b1, 1'b0, 16'h1234, 4'hF, 32'h0, bc);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", rd_data, e); end
        bus_xfer(1'b0, 1'b1, 16'h1234, 4'hF, 32'hDEAD_BEEF, bc);
        checks++; if (bc !== 2) begin failures++; $display("FAIL unmapped_wr_busy got=%0d exp=2", bc); end
        checks++; if (mtimecmp !== 64'h0000_AB00 || msip !== 32'h1) begin failures++; $display("FAIL unmapped_wr_side got=%h/%h exp=%h/%h", mtimecmp, msip, 64'h0000_AB00, 32'h1); end
    endtask

    task automatic test_rd_wr_both();
        int bc;
        logic [31:0] e;
        exp_q.push_back(32'h0000_AB00);
        bus_xfer(1'b1, 1'b0, 16'h4000, 4'hF, 32'h0, bc);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin failures++; $display("FAIL both_preread got=%h exp=%h", rd_data, e); end
        bus_xfer(1'b1, 1'b1, 16'h0000, 4'hF, 32'h0, bc);
        checks++; if (msip !== 32'h0) begin failures++; $display("FAIL both_write got=%h exp=%h", msip, 32'h0); end
        checks++; if (rd_data !== 32'h0000_AB00) begin failures++; $display("FAIL both_rd_hold got=%h exp=%h", rd_data, 32'h0000_AB00); end
    endtask

    task automatic test_reset_in_access();
        @(posedge clk); #1;
        wr_en = 1'b1; addr = 16'h4000; byte_en = 4'hF; wr_data = 32'h55;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_req_busy got=%b exp=1", busy); end
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (mtimecmp !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL abort_mtimecmp got=%h exp=%h", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF); end
    endtask

    task automatic test_back_to_back();
        int bc;
        logic [31:0] e;
        bus_xfer(1'b0, 1'b1, 16'h0000, 4'h1, 32'h1, bc);
        checks++; if (bc !== 2 || msip !== 32'h1) begin failures++; $display("FAIL b2b_write got=%0d/%h exp=2/%h", bc, msip, 32'h1); end
        exp_q.push_back(32'h1);
        bus_xfer(1'b1, 1'b0, 16'h0000, 4'hF, 32'h0, bc);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin failures++; $display("FAIL b2b_read0 got=%h exp=%h", rd_data, e); end
        exp_q.push_back(32'hFFFF_FFFF);
        bus_xfer(1'b1, 1'b0, 16'h4004, 4'hF, 32'h0, bc);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin failures++; $display("FAIL b2b_read1 got=%h exp=%h", rd_data, e); end
    endtask

    initial begin
        test_reset();
        test_msip();
        test_mtimecmp_halves();
        test_byte_merge();
        test_mtime_collision();
        test_read_hold();
        test_unmapped();
        test_rd_wr_both();
        test_reset_in_access();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
